// File: rtl/pmt_gate_counter.sv
// PMT photon gate counter: synchronised edge detect, gated window count, FWFT result FIFO.
// Optional PMT_COUNT_SATURATE_EN: the count saturates instead of wrapping on overflow.
module pmt_gate_counter #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GATE_W     = 24,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pmt_in,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [GATE_W-1:0] gate_len,
    output logic [CNT_W:0]    out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GATE,
        S_LATCH
    } state_e;

    state_e             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic               pmt_edge;
    logic [GATE_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d, count_inc;
    logic               ovf_q, ovf_d, inc_ovf;
    logic               cont_q, cont_d;
    logic               overrun_q, overrun_d;
    logic               push, push_ok, pop, full, empty;
    logic [CNT_W:0]     mem_q [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_q, rd_ptr_q;

    assign pmt_edge = s2_q & ~s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pmt_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_comb begin
        count_inc = count_q;
        inc_ovf   = ovf_q;
        if (pmt_edge) begin
            if (&count_q) begin
                inc_ovf = 1'b1;
`ifdef PMT_COUNT_SATURATE_EN
                count_inc = count_q;
`else
                count_inc = '0;
`endif
            end else begin
                count_inc = count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        cont_d    = cont_q;
        overrun_d = overrun_q;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop && (gate_len != '0)) begin
                    timer_d   = gate_len;
                    count_d   = '0;
                    ovf_d     = 1'b0;
                    cont_d    = continuous;
                    overrun_d = 1'b0;
                    state_d   = S_GATE;
                end
            end
            S_GATE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = count_inc;
                    ovf_d   = inc_ovf;
                    timer_d = timer_q - 1'b1;
                    if (timer_q == GATE_W'(1)) state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                push = 1'b1;
                if (full && !pop) overrun_d = 1'b1;
                // Reload counts the LATCH-cycle edge so no edge falls between windows.
                if (cont_q && !stop && (gate_len != '0)) begin
                    timer_d = gate_len;
                    count_d = CNT_W'(pmt_edge);
                    ovf_d   = 1'b0;
                    state_d = S_GATE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            cont_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            cont_q    <= cont_d;
            overrun_q <= overrun_d;
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = out_valid & out_ready;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {ovf_q, count_q};
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule
